// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Stimulus/response engine for small combinational gates. A run drives every
//   input combination to the gate in ascending order. It holds each vector for
//   a settle window and then samples the gate output. It compares each sample
//   against the TRUTH_TABLE parameter. Bit i of TRUTH_TABLE is the expected
//   output for stim == i.
//
// Ports
//   clk              in   1         rising-edge clock
//   rst_n            in   1         asynchronous active-low reset
//   start            in   1         begin a run (accepted in IDLE or DONE only)
//   abort            in   1         cancel a run and return to IDLE
//   dut_out          in   1         output of the gate under test
//   stim             out  N_INPUTS  gate inputs (for N=2: stim[1]=a, stim[0]=b)
//   busy             out  1         run in progress (SETTLE)
//   done             out  1         run complete, held until start/abort/reset
//   pass             out  1         done with zero mismatches
//   err_count        out  ERR_W     saturating mismatch count
//   first_fail_vec   out  N_INPUTS  stim value of the first mismatch
//   first_fail_valid out  1         first_fail_vec holds a captured value
//   state_dbg        out  2         current FSM state (0 IDLE, 1 SETTLE, 2 DONE)
//
// Control semantics: start and abort are single-cycle level requests sampled
// on every rising edge; there is no ready back-pressure. start is acted on
// only in IDLE or DONE and is ignored in SETTLE. abort is acted on in every
// state and takes priority over start.

module gate_truth_table_checker #(
  parameter int N_INPUTS      = 2,
  parameter     TRUTH_TABLE   = 4'b1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dut_out,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid,
  output logic [1:0]          state_dbg
);

  localparam int NV = 1 << N_INPUTS;

  // The table must have exactly one bit per input combination.
  if ($bits(TRUTH_TABLE) != NV) begin : g_bad_truth_table
    $error("TRUTH_TABLE width must equal 2**N_INPUTS");
  end
  if (N_INPUTS < 1 || N_INPUTS > 8) begin : g_bad_n_inputs
    $error("N_INPUTS must be in 1..8");
  end
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 0..255");
  end

  localparam logic [NV-1:0] TT     = TRUTH_TABLE;
  localparam logic [7:0]    CNT_LD = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_INPUTS-1:0] stim_q, stim_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;
  logic [N_INPUTS-1:0] first_fail_vec_q, first_fail_vec_d;
  logic                first_fail_valid_q, first_fail_valid_d;
  logic                mismatch;

  // An X or Z on dut_out makes the equality unknown. The if then falls
  // through, so such a sample counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (dut_out == TT[stim_q]) mismatch = 1'b0;
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    stim_d             = stim_q;
    err_count_d        = err_count_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;

    if (abort) begin
      // Partial results (err_count, first_fail_*) are deliberately kept.
      state_d = ST_IDLE;
      stim_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d            = ST_SETTLE;
            stim_d             = '0;
            cnt_d              = CNT_LD;
            err_count_d        = '0;
            first_fail_vec_d   = '0;
            first_fail_valid_d = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            // Sampling edge for the vector currently on stim.
            if (mismatch) begin
              if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
              if (!first_fail_valid_q) begin
                first_fail_vec_d   = stim_q;
                first_fail_valid_d = 1'b1;
              end
            end
            if (stim_q == '1) begin
              state_d = ST_DONE;
            end else begin
              stim_d = stim_q + N_INPUTS'(1);
              cnt_d  = CNT_LD;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          stim_d  = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_SETTLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      cnt_q              <= 8'd0;
      stim_q             <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      err_count_q        <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      stim_q             <= stim_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      err_count_q        <= err_count_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (err_count_q == '0);
  assign err_count        = err_count_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: correct 2-input AND, defaults ----------------
  logic       start_a, abort_a;
  logic [1:0] stim_a, ffv_a_vec, state_a;
  logic       busy_a, done_a, pass_a, ffv_a;
  logic [7:0] err_a;
  logic       out_a;
  assign out_a = stim_a[1] & stim_a[0];

  gate_truth_table_checker u_and (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(out_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a_vec), .first_fail_valid(ffv_a), .state_dbg(state_a)
  );

  // ---------------- instance B: OR gate checked against AND table ----------------
  logic       start_g, abort_g;
  logic [1:0] stim_b, ffv_b_vec, state_b;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [7:0] err_b;
  logic       out_b;
  assign out_b = stim_b[1] | stim_b[0];

  gate_truth_table_checker u_or (
    .clk(clk), .rst_n(rst_n), .start(start_g), .abort(abort_g), .dut_out(out_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b_vec), .first_fail_valid(ffv_b), .state_dbg(state_b)
  );

  // ---------------- instance C: output stuck at 1, ERR_W=1 ----------------
  logic [1:0] stim_c, ffv_c_vec, state_c;
  logic       busy_c, done_c, pass_c, ffv_c;
  logic [0:0] err_c;
  logic       out_c;
  assign out_c = 1'b1;

  gate_truth_table_checker #(.ERR_W(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_g), .abort(abort_g), .dut_out(out_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ffv_c_vec), .first_fail_valid(ffv_c), .state_dbg(state_c)
  );

  // ---------------- instance D: 3-input AND, no settle ----------------
  logic       start_d, abort_d;
  logic [2:0] stim_d, ffv_d_vec;
  logic [1:0] state_d;
  logic       busy_d, done_d, pass_d, ffv_d;
  logic [7:0] err_d;
  logic       out_d;
  assign out_d = &stim_d;

  gate_truth_table_checker #(.N_INPUTS(3), .TRUTH_TABLE(8'h80), .SETTLE_CYCLES(0)) u_and3 (
    .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .dut_out(out_d),
    .stim(stim_d), .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
    .first_fail_vec(ffv_d_vec), .first_fail_valid(ffv_d), .state_dbg(state_d)
  );

  // ---------------- driver tasks ----------------
  // Returns 1 time unit after a rising edge, so outputs reflect that edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_g = 1'b0; abort_g = 1'b0;
    start_d = 1'b0; abort_d = 1'b0;

    #12;
    chk("rst_stim",  32'(stim_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_pass",  32'(pass_a), 32'd0);
    chk("rst_err",   32'(err_a),  32'd0);
    chk("rst_ffv",   32'(ffv_a),  32'd0);
    chk("rst_ffvec", 32'(ffv_a_vec), 32'd0);
    chk("rst_state", 32'(state_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Run 1: A, B, C start together at edge k.
    start_a = 1'b1; start_g = 1'b1;
    tick();                              // edge k
    start_a = 1'b0; start_g = 1'b0;
    chk("r1_k_stim", 32'(stim_a), 32'd0);
    chk("r1_k_busy", 32'(busy_a), 32'd1);
    chk("r1_k_state", 32'(state_a), 32'd1);
    tick(2);                             // k+2
    chk("r1_k2_stim", 32'(stim_a), 32'd0);
    start_a = 1'b1;                      // start while busy, ignored
    tick();                              // k+3
    start_a = 1'b0;
    chk("r1_k3_stim", 32'(stim_a), 32'd1);
    tick(3);                             // k+6
    chk("r1_k6_stim", 32'(stim_a), 32'd2);
    start_a = 1'b1;
    tick();                              // k+7
    start_a = 1'b0;
    tick(2);                             // k+9
    chk("r1_k9_stim", 32'(stim_a), 32'd3);
    chk("r1_k9_busy", 32'(busy_a), 32'd1);
    tick(2);                             // k+11
    chk("r1_k11_done", 32'(done_a), 32'd0);
    tick();                              // k+12
    chk("and_done",  32'(done_a), 32'd1);
    chk("and_busy",  32'(busy_a), 32'd0);
    chk("and_pass",  32'(pass_a), 32'd1);
    chk("and_err",   32'(err_a),  32'd0);
    chk("and_ffv",   32'(ffv_a),  32'd0);
    chk("and_stim_hold", 32'(stim_a), 32'd3);
    chk("or_done",   32'(done_b), 32'd1);
    chk("or_err",    32'(err_b),  32'd2);
    chk("or_ffvec",  32'(ffv_b_vec), 32'd1);
    chk("or_ffv",    32'(ffv_b),  32'd1);
    chk("or_pass",   32'(pass_b), 32'd0);
    chk("one_err_sat", 32'(err_c), 32'd1);
    chk("one_ffvec", 32'(ffv_c_vec), 32'd0);
    chk("one_ffv",   32'(ffv_c),  32'd1);
    chk("one_pass",  32'(pass_c), 32'd0);
    tick(3);
    chk("and_done_held", 32'(done_a), 32'd1);

    // Run 2: restart from DONE clears results.
    start_a = 1'b1; start_g = 1'b1;
    tick();                              // edge k'
    start_a = 1'b0; start_g = 1'b0;
    chk("r2_done_clr", 32'(done_a), 32'd0);
    chk("r2_busy",     32'(busy_a), 32'd1);
    chk("r2_or_err_clr", 32'(err_b), 32'd0);
    chk("r2_or_ffv_clr", 32'(ffv_b), 32'd0);
    chk("r2_or_ffvec_clr", 32'(ffv_b_vec), 32'd0);
    tick(12);                            // k'+12
    chk("r2_and_done", 32'(done_a), 32'd1);
    chk("r2_and_pass", 32'(pass_a), 32'd1);
    chk("r2_or_err",   32'(err_b),  32'd2);

    // Abort: A at k+5, abort+start at k+6, B/C at k+7.
    start_a = 1'b1; start_g = 1'b1;
    tick();                              // k
    start_a = 1'b0; start_g = 1'b0;
    tick(4);                             // k+4
    chk("ab_k4_stim", 32'(stim_a), 32'd1);
    abort_a = 1'b1;
    tick();                              // k+5
    abort_a = 1'b0;
    chk("ab_busy",  32'(busy_a), 32'd0);
    chk("ab_done",  32'(done_a), 32'd0);
    chk("ab_stim",  32'(stim_a), 32'd0);
    chk("ab_state", 32'(state_a), 32'd0);
    chk("ab_or_still_busy", 32'(busy_b), 32'd1);
    abort_a = 1'b1; start_a = 1'b1;
    tick();                              // k+6
    abort_a = 1'b0; start_a = 1'b0;
    chk("ab_start_busy", 32'(busy_a), 32'd0);
    abort_g = 1'b1;
    tick();                              // k+7
    abort_g = 1'b0;
    chk("ab_or_busy",  32'(busy_b), 32'd0);
    chk("ab_or_stim",  32'(stim_b), 32'd0);
    chk("ab_or_err",   32'(err_b),  32'd1);
    chk("ab_or_ffv",   32'(ffv_b),  32'd1);
    chk("ab_or_ffvec", 32'(ffv_b_vec), 32'd1);

    // Asynchronous reset mid-run.
    start_a = 1'b1; start_g = 1'b1;
    tick();                              // k
    start_a = 1'b0; start_g = 1'b0;
    tick(4);                             // k+4
    chk("ar_pre_busy", 32'(busy_a), 32'd1);
    chk("ar_pre_err",  32'(err_c),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;                                  // well before the next edge
    chk("ar_stim", 32'(stim_a), 32'd0);
    chk("ar_busy", 32'(busy_a), 32'd0);
    chk("ar_err",  32'(err_c),  32'd0);
    chk("ar_ffv",  32'(ffv_c),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 3-input AND with no settle window.
    start_d = 1'b1;
    tick();                              // k
    start_d = 1'b0;
    chk("a3_k_stim", 32'(stim_d), 32'd0);
    chk("a3_k_busy", 32'(busy_d), 32'd1);
    tick();                              // k+1
    chk("a3_k1_stim", 32'(stim_d), 32'd1);
    tick(6);                             // k+7
    chk("a3_k7_stim", 32'(stim_d), 32'd7);
    chk("a3_k7_done", 32'(done_d), 32'd0);
    tick();                              // k+8
    chk("a3_done", 32'(done_d), 32'd1);
    chk("a3_pass", 32'(pass_d), 32'd1);
    chk("a3_err",  32'(err_d),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
